// File: rtl/fifo_rr_arbiter_pkg.sv
// ============================================================================
// Package : fifo_arb_pkg
// Shared arbiter state type, statistics width and a constant clog2 helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int STATS_W = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Combinational round-robin pick: rotate, priority-encode, unrotate.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int REQ_CNT = 4,
  parameter int SRC_W   = clog2(REQ_CNT)
) (
  input  logic [REQ_CNT-1:0] req_valid,
  input  logic [SRC_W-1:0]   last_grant,
  output logic [SRC_W-1:0]   winner,
  output logic               any_valid
);

  logic [SRC_W-1:0]   w_start;
  logic [SRC_W-1:0]   w_offset;
  logic [REQ_CNT-1:0] w_rot;
  logic [SRC_W:0]     w_sum;

  assign w_start = (last_grant >= SRC_W'(REQ_CNT - 1)) ? '0 : last_grant + SRC_W'(1);

  // Doubling the vector makes the rotate a plain right shift.
  assign w_rot = REQ_CNT'({req_valid, req_valid} >> w_start);

  always_comb begin
    w_offset = '0;
    for (int i = REQ_CNT - 1; i >= 0; i--) begin
      if (w_rot[i]) w_offset = SRC_W'(i);
    end
  end

  assign w_sum     = {1'b0, w_start} + {1'b0, w_offset};
  assign winner    = (w_sum >= (SRC_W + 1)'(REQ_CNT)) ? SRC_W'(w_sum - (SRC_W + 1)'(REQ_CNT))
                                                      : w_sum[SRC_W-1:0];
  assign any_valid = |req_valid;

endmodule

`default_nettype wire

// File: rtl/fifo_rr_arbiter.sv
// ============================================================================
// Module  : fifo_rr_arbiter
// Burst round-robin arbiter feeding one FIFO write port through an output
// register. Optional per-requester grant counters under FIFO_ARB_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int REQ_CNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int SRC_W      = clog2(REQ_CNT)
) (
  input  logic                          clock_port,
  input  logic                          reset_port,
`ifdef FIFO_ARB_STATS_EN
  input  logic                          stats_clr,
  output logic [REQ_CNT*STATS_W-1:0]    grant_cnt,
`endif
  input  logic [REQ_CNT*DATA_WIDTH-1:0] req_data,
  input  logic [REQ_CNT-1:0]            req_valid,
  output logic [REQ_CNT-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]              out_src,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy
);

  localparam int c_BEAT_W = clog2(MAX_BURST + 1);

  arb_state_t            r_state;
  logic [SRC_W-1:0]      r_last_grant;
  logic [c_BEAT_W-1:0]   r_beat_cnt;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [SRC_W-1:0]      r_out_src;

  logic [SRC_W-1:0]      w_winner;
  logic [SRC_W-1:0]      w_sel;
  logic                  w_any_valid;
  logic                  w_pipe_ready;
  logic                  w_xfer;
  logic [REQ_CNT-1:0]    w_req_ready;
  logic [c_BEAT_W-1:0]   w_beat_next;
  logic [DATA_WIDTH-1:0] w_data_arr [REQ_CNT];

  for (genvar g_i = 0; g_i < REQ_CNT; g_i++) begin : g_unpack
    assign w_data_arr[g_i] = req_data[g_i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .REQ_CNT (REQ_CNT),
    .SRC_W   (SRC_W)
  ) u_pick (
    .req_valid  (req_valid),
    .last_grant (r_last_grant),
    .winner     (w_winner),
    .any_valid  (w_any_valid)
  );

  assign w_pipe_ready = ~r_out_valid | out_ready;
  assign w_sel        = (r_state == IDLE) ? w_winner : r_last_grant;
  assign w_beat_next  = r_beat_cnt + c_BEAT_W'(1);

  always_comb begin
    w_req_ready = '0;
    if (reset_port) begin
      if (r_state == IDLE) begin
        if (w_any_valid && w_pipe_ready) w_req_ready[w_winner] = 1'b1;
      end else begin
        w_req_ready[r_last_grant] = w_pipe_ready;
      end
    end
  end

  assign w_xfer = |(w_req_ready & req_valid);

  always_ff @(posedge clock_port or negedge reset_port) begin
    if (!reset_port) begin
      r_state      <= IDLE;
      r_last_grant <= SRC_W'(REQ_CNT - 1);
      r_beat_cnt   <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_src    <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data_arr[w_sel];
        r_out_src   <= w_sel;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_last_grant <= w_winner;
            if (MAX_BURST > 1) begin
              r_state    <= LOCK;
              r_beat_cnt <= c_BEAT_W'(1);
            end
          end
        end
        LOCK: begin
          if (w_xfer) begin
            if (w_beat_next == c_BEAT_W'(MAX_BURST)) begin
              r_state    <= IDLE;
              r_beat_cnt <= '0;
            end else begin
              r_beat_cnt <= w_beat_next;
            end
          end else if (w_pipe_ready) begin
            // Pipe could take a beat but the owner has none: release early.
            r_state    <= IDLE;
            r_beat_cnt <= '0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_beat_cnt <= '0;
        end
      endcase
    end
  end

  assign req_ready = w_req_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign busy      = (r_state == LOCK);

`ifdef FIFO_ARB_STATS_EN
  for (genvar g_s = 0; g_s < REQ_CNT; g_s++) begin : g_stats
    logic [STATS_W-1:0] r_cnt;

    always_ff @(posedge clock_port or negedge reset_port) begin
      if (!reset_port) begin
        r_cnt <= '0;
      end else if (stats_clr) begin
        r_cnt <= '0;
      end else if (req_valid[g_s] && w_req_ready[g_s] && (r_cnt != {STATS_W{1'b1}})) begin
        r_cnt <= r_cnt + STATS_W'(1);
      end
    end

    assign grant_cnt[g_s*STATS_W +: STATS_W] = r_cnt;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rr_arbiter.sv
// ============================================================================
// Module  : tb_fifo_rr_arbiter
// Directed bench for fifo_rr_arbiter with a queue-based output scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rr_arbiter;
  import fifo_arb_pkg::*;

  localparam int REQ_CNT   = 4;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;
  localparam int SRC_W     = 2;

  logic                   clock_port;
  logic                   reset_port;
  logic [REQ_CNT*DW-1:0]  req_data;
  logic [REQ_CNT-1:0]     req_valid;
  logic [REQ_CNT-1:0]     req_ready;
  logic [DW-1:0]          out_data;
  logic [SRC_W-1:0]       out_src;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;
`ifdef FIFO_ARB_STATS_EN
  logic                   stats_clr;
  logic [REQ_CNT*STATS_W-1:0] grant_cnt;
`endif

  int checks;
  int errors;
  int beats_seen;
  int prod_left [REQ_CNT];
  int sent      [REQ_CNT];
  logic [SRC_W+DW-1:0] exp_q [$];

  fifo_rr_arbiter #(
    .REQ_CNT    (REQ_CNT),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MAX_BURST),
    .SRC_W      (SRC_W)
  ) dut (
    .clock_port (clock_port),
    .reset_port (reset_port),
`ifdef FIFO_ARB_STATS_EN
    .stats_clr  (stats_clr),
    .grant_cnt  (grant_cnt),
`endif
    .req_data   (req_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  initial begin
    clock_port = 1'b0;
    forever #5 clock_port = ~clock_port;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input int s, input int d);
    exp_q.push_back({SRC_W'(s), DW'(d)});
  endtask

  // Producer i offers payload i*16 + beats already sent, while beats remain.
  task automatic drive();
    for (int i = 0; i < REQ_CNT; i++) begin
      req_valid[i]           = (prod_left[i] != 0);
      req_data[i*DW +: DW]   = DW'(i*16 + sent[i]);
    end
  endtask

  task automatic tick();
    logic [REQ_CNT-1:0] fire;
    @(negedge clock_port);
    fire = req_valid & req_ready;
    @(posedge clock_port);
    #1;
    for (int i = 0; i < REQ_CNT; i++) begin
      if (fire[i]) begin
        prod_left[i]--;
        sent[i]++;
      end
    end
    drive();
    #1;
  endtask

  always @(negedge clock_port) begin
    if (reset_port && out_valid && out_ready) begin
      logic [SRC_W+DW-1:0] e;
      beats_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat actual src=%0d data=%0h required=none", out_src, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_src, out_data} !== e) begin
          errors++;
          $display("FAIL beat actual src=%0d data=%0h required src=%0d data=%0h",
                   out_src, out_data, e[SRC_W+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    int base;
    checks     = 0;
    errors     = 0;
    beats_seen = 0;
    reset_port = 1'b0;
    out_ready  = 1'b1;
    req_data   = '0;
    req_valid  = '0;
`ifdef FIFO_ARB_STATS_EN
    stats_clr  = 1'b0;
`endif
    for (int i = 0; i < REQ_CNT; i++) begin
      prod_left[i] = 4;
      sent[i]      = 0;
    end
    drive();

    // Reset with every requester valid, then round robin over all four.
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_out_data",  32'(out_data),  32'h0);
    check("rst_out_src",   32'(out_src),   32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    for (int s = 0; s < REQ_CNT; s++)
      for (int k = 0; k < 4; k++) expect_beat(s, s*16 + k);
    reset_port = 1'b1;
    #1;
    check("first_grant", 32'(req_ready), 32'h1);
    base = beats_seen;
    tick();
    check("lock_busy",  32'(busy),      32'h1);
    check("lock_ready", 32'(req_ready), 32'h1);
    repeat (16) tick();
    check("rr_no_bubble", 32'(beats_seen - base), 32'd16);

    // Early burst end: requester 1 gives 2 beats, then requester 3.
    prod_left[1] = 2;
    prod_left[3] = 3;
    drive();
    expect_beat(1, 8'h14);
    expect_beat(1, 8'h15);
    expect_beat(3, 8'h34);
    expect_beat(3, 8'h35);
    expect_beat(3, 8'h36);
    base = beats_seen;
    tick();
    tick();
    check("early_lock_ready", 32'(req_ready), 32'h2);
    check("early_lock_busy",  32'(busy),      32'h1);
    tick();
    check("early_idle_ready", 32'(req_ready), 32'h8);
    check("early_idle_busy",  32'(busy),      32'h0);
    repeat (4) tick();
    check("early_beats", 32'(beats_seen - base), 32'd5);

    // Backpressure mid-burst from requester 0.
    prod_left[0] = 4;
    drive();
    for (int k = 4; k < 8; k++) expect_beat(0, k);
    base = beats_seen;
    tick();
    out_ready = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      check("bp_hold", {20'h0, req_ready, out_valid, 1'b0, out_src, out_data},
                       {20'h0, 4'h0, 1'b1, 1'b0, 2'd0, 8'h04});
      check("bp_busy", 32'(busy), 32'h1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    repeat (3) tick();
    check("bp_burst_end", 32'(busy), 32'h0);
    tick();
    check("bp_beats", 32'(beats_seen - base), 32'd4);

    // Reset mid-burst drops the in-flight beat and restores priority to 0.
    prod_left[1] = 4;
    drive();
    expect_beat(1, 8'h16);
    tick();
    tick();
    reset_port   = 1'b0;
    prod_left[0] = 2;
    drive();
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    check("mid_rst_busy",  32'(busy),      32'h0);
    expect_beat(0, 8'h08);
    expect_beat(0, 8'h09);
    expect_beat(1, 8'h18);
    expect_beat(1, 8'h19);
    tick();
    tick();
    reset_port = 1'b1;
    #1;
    check("post_rst_grant", 32'(req_ready), 32'h1);
    repeat (8) tick();

`ifdef FIFO_ARB_STATS_EN
    prod_left[2] = 10;
    drive();
    for (int k = 4; k < 14; k++) expect_beat(2, 8'h20 + k);
    repeat (14) tick();
    check("stats_req2", 32'(grant_cnt[2*STATS_W +: STATS_W]), 32'd10);
    check("stats_req1", 32'(grant_cnt[1*STATS_W +: STATS_W]), 32'd2);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    #1;
    check("stats_clr", 32'(grant_cnt[2*STATS_W +: STATS_W]), 32'd0);
`endif

    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
